// File: rtl/kms_event_scheduler_pkg.sv
// Shared types for the keyboard/mouse/OSD event scheduler: event encoding,
// the packed FIFO entry and the dispatcher states.
package minimig_kms_pkg;

    localparam logic [1:0] KMS_MOUSE_X = 2'd0;
    localparam logic [1:0] KMS_MOUSE_Y = 2'd1;
    localparam logic [1:0] KMS_KEY     = 2'd2;
    localparam logic [1:0] KMS_OSD     = 2'd3;

    typedef struct packed {
        logic [1:0] ev_type;
        logic [7:0] data;
    } kms_event_t;

    typedef enum logic {
        IDLE     = 1'b0,
        KBD_WAIT = 1'b1
    } kms_state_e;

endpackage

// File: rtl/kms_event_scheduler_if.sv
// Event input bus from the HPS UIO decoder plus the keyboard serializer
// req/ack handshake, bundled so both ends see the same signal set.
interface kms_event_scheduler_if;

    logic       kms_level;
    logic [1:0] kms_type;
    logic [7:0] kms_data;
    logic       kbd_req;
    logic [7:0] kbd_code;
    logic       kbd_ack;

    modport master (
        output kms_level,
        output kms_type,
        output kms_data,
        output kbd_ack,
        input  kbd_req,
        input  kbd_code
    );

    modport slave (
        input  kms_level,
        input  kms_type,
        input  kms_data,
        input  kbd_ack,
        output kbd_req,
        output kbd_code
    );

endinterface

// File: rtl/kms_event_scheduler_fifo.sv
// Synchronous event FIFO built on a register array; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module kms_fifo
    import minimig_kms_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       push,
    input  kms_event_t push_data,
    input  logic       pop,
    output kms_event_t pop_data,
    output logic       empty,
    output logic       full,
    output logic [AW:0] level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   DEPTH_C   = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);

    kms_event_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = count_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/kms_event_scheduler.sv
// Captures toggle-signalled keyboard/mouse/OSD events into a FIFO and
// dispatches them in order: keycodes over req/ack, OSD keys as strobes, mouse deltas into saturating accumulators.
module kms_event_scheduler
    import minimig_kms_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int ACC_W   = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    kms_event_scheduler_if.slave bus,
    input  logic [2:0]           mouse_btn_in,
    output logic                 osd_stb,
    output logic [7:0]           osd_code,
    output logic [ACC_W-1:0]     mouse_dx,
    output logic [ACC_W-1:0]     mouse_dy,
    input  logic                 mouse_rd,
    output logic [2:0]           mouse_btn,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 overflow
);

    kms_state_e       state_q, state_d;
    logic             level_q;
    logic             kbd_req_q, kbd_req_d;
    logic [7:0]       kbd_code_q, kbd_code_d;
    logic             osd_stb_q, osd_stb_d;
    logic [7:0]       osd_code_q, osd_code_d;
    logic [ACC_W-1:0] dx_q, dx_d;
    logic [ACC_W-1:0] dy_q, dy_d;
    logic [2:0]       btn_q;
    logic             overflow_q, overflow_d;

    logic             push_req;
    kms_event_t       push_ev;
    kms_event_t       head;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;

    // Widen by one bit so the true sum is visible, then clamp on signed overflow.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [7:0]       delta);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W - 7){delta[7]}}, delta};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end
        return sum[ACC_W-1:0];
    endfunction

    assign push_req = (bus.kms_level != level_q);
    assign push_ev  = '{ev_type: bus.kms_type, data: bus.kms_data};

    kms_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (push_ev),
        .pop       (fifo_pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // A mouse_rd clears both accumulators; a mouse pop in the same cycle
    // then starts its accumulator afresh from the new delta.
    always_comb begin
        state_d    = state_q;
        kbd_req_d  = kbd_req_q;
        kbd_code_d = kbd_code_q;
        osd_stb_d  = 1'b0;
        osd_code_d = osd_code_q;
        dx_d       = mouse_rd ? '0 : dx_q;
        dy_d       = mouse_rd ? '0 : dy_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (head.ev_type)
                        KMS_MOUSE_X: dx_d = sat_add(mouse_rd ? '0 : dx_q, head.data);
                        KMS_MOUSE_Y: dy_d = sat_add(mouse_rd ? '0 : dy_q, head.data);
                        KMS_OSD: begin
                            osd_code_d = head.data;
                            osd_stb_d  = 1'b1;
                        end
                        default: begin
                            kbd_code_d = head.data;
                            kbd_req_d  = 1'b1;
                            state_d    = KBD_WAIT;
                        end
                    endcase
                end
            end
            KBD_WAIT: begin
                if (bus.kbd_ack) begin
                    kbd_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_req && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            level_q    <= 1'b0;
            kbd_req_q  <= 1'b0;
            kbd_code_q <= '0;
            osd_stb_q  <= 1'b0;
            osd_code_q <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            btn_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= bus.kms_level;
            kbd_req_q  <= kbd_req_d;
            kbd_code_q <= kbd_code_d;
            osd_stb_q  <= osd_stb_d;
            osd_code_q <= osd_code_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            btn_q      <= mouse_btn_in;
            overflow_q <= overflow_d;
        end
    end

    assign bus.kbd_req  = kbd_req_q;
    assign bus.kbd_code = kbd_code_q;
    assign osd_stb      = osd_stb_q;
    assign osd_code     = osd_code_q;
    assign mouse_dx     = dx_q;
    assign mouse_dy     = dy_q;
    assign mouse_btn    = btn_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_kms_event_scheduler.sv
// Directed bench for kms_event_scheduler: keycode/OSD dispatches are checked
// against a scoreboard queue, mouse accumulators and FIFO status directly.
module tb_kms_event_scheduler;
    import minimig_kms_pkg::*;

    logic       clock = 1'b0;
    logic       resetN;
    logic [2:0] mouseBtnIn;
    logic       osdStb;
    logic [7:0] osdCode;
    logic [7:0] mouseDx;
    logic [7:0] mouseDy;
    logic       mouseRd;
    logic [2:0] mouseBtn;
    logic [3:0] fifoLevel;
    logic       overflow;

    int checks  = 0;
    int errors  = 0;
    int kbdSeen = 0;
    int osdSeen = 0;
    int base;
    logic       prevReq = 1'b0;
    logic [9:0] sbQ[$];
    logic [9:0] expEv;

    kms_event_scheduler_if bus();

    kms_event_scheduler #(
        .FIFO_AW (3),
        .ACC_W   (8)
    ) dut (
        .clk_sys      (clock),
        .reset_n      (resetN),
        .bus          (bus),
        .mouse_btn_in (mouseBtnIn),
        .osd_stb      (osdStb),
        .osd_code     (osdCode),
        .mouse_dx     (mouseDx),
        .mouse_dy     (mouseDy),
        .mouse_rd     (mouseRd),
        .mouse_btn    (mouseBtn),
        .fifo_level   (fifoLevel),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] evType, input logic [7:0] evData, input bit expectOut);
        @(negedge clock);
        bus.kms_type  = evType;
        bus.kms_data  = evData;
        bus.kms_level = ~bus.kms_level;
        if (expectOut && (evType == KMS_KEY || evType == KMS_OSD)) begin
            sbQ.push_back({evType, evData});
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulseAck();
        @(negedge clock);
        bus.kbd_ack = 1'b1;
        @(negedge clock);
        bus.kbd_ack = 1'b0;
    endtask

    task automatic pulseMouseRd();
        @(negedge clock);
        mouseRd = 1'b1;
        @(negedge clock);
        mouseRd = 1'b0;
    endtask

    task automatic waitReq(input int maxCycles);
        int n = 0;
        while (!bus.kbd_req && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput("kbd_req_timeout", {15'b0, bus.kbd_req}, 16'd1);
    endtask

    // Every new keycode request or OSD strobe must match the oldest expected dispatch.
    always @(negedge clock) begin
        if (bus.kbd_req && !prevReq) begin
            kbdSeen++;
            if (sbQ.size() == 0) begin
                checkOutput("kbd_unexpected", {6'b0, KMS_KEY, bus.kbd_code}, 16'hFFFF);
            end else begin
                expEv = sbQ.pop_front();
                checkOutput("kbd_dispatch", {6'b0, KMS_KEY, bus.kbd_code}, {6'b0, expEv});
            end
        end
        if (osdStb) begin
            osdSeen++;
            if (sbQ.size() == 0) begin
                checkOutput("osd_unexpected", {6'b0, KMS_OSD, osdCode}, 16'hFFFF);
            end else begin
                expEv = sbQ.pop_front();
                checkOutput("osd_dispatch", {6'b0, KMS_OSD, osdCode}, {6'b0, expEv});
            end
        end
        prevReq = bus.kbd_req;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetN        = 1'b0;
        bus.kms_level = 1'b0;
        bus.kms_type  = 2'd0;
        bus.kms_data  = 8'h00;
        bus.kbd_ack   = 1'b0;
        mouseBtnIn    = 3'b000;
        mouseRd       = 1'b0;

        waitCycles(3);
        checkOutput("rst_kbd_req", {15'b0, bus.kbd_req}, 16'd0);
        checkOutput("rst_osd_stb", {15'b0, osdStb}, 16'd0);
        checkOutput("rst_dx", {8'b0, mouseDx}, 16'd0);
        checkOutput("rst_dy", {8'b0, mouseDy}, 16'd0);
        checkOutput("rst_level", {12'b0, fifoLevel}, 16'd0);
        checkOutput("rst_overflow", {15'b0, overflow}, 16'd0);
        checkOutput("rst_btn", {13'b0, mouseBtn}, 16'd0);
        resetN = 1'b1;

        mouseBtnIn = 3'b101;
        @(negedge clock);
        checkOutput("btn_reg", {13'b0, mouseBtn}, 16'h0005);

        // Keycode handshake with a slow serializer.
        applyStimulus(KMS_KEY, 8'h45, 1'b1);
        @(negedge clock);
        checkOutput("t1_level_after_push", {12'b0, fifoLevel}, 16'd1);
        checkOutput("t1_req_not_yet", {15'b0, bus.kbd_req}, 16'd0);
        @(negedge clock);
        checkOutput("t1_req_rise", {15'b0, bus.kbd_req}, 16'd1);
        checkOutput("t1_code", {8'b0, bus.kbd_code}, 16'h0045);
        waitCycles(20);
        checkOutput("t1_req_held", {15'b0, bus.kbd_req}, 16'd1);
        pulseAck();
        checkOutput("t1_req_fall", {15'b0, bus.kbd_req}, 16'd0);

        // Mouse and OSD events wait behind an unacknowledged keycode.
        base = osdSeen;
        applyStimulus(KMS_KEY, 8'h10, 1'b1);
        applyStimulus(KMS_MOUSE_X, 8'h05, 1'b1);
        applyStimulus(KMS_OSD, 8'h81, 1'b1);
        waitCycles(5);
        #1;
        checkOutput("t2_dx_blocked", {8'b0, mouseDx}, 16'd0);
        checkOutput("t2_osd_blocked", 16'(osdSeen - base), 16'd0);
        checkOutput("t2_level", {12'b0, fifoLevel}, 16'd2);
        pulseAck();
        checkOutput("t2_dx_before_pop", {8'b0, mouseDx}, 16'd0);
        @(negedge clock);
        checkOutput("t2_dx", {8'b0, mouseDx}, 16'd5);
        checkOutput("t2_osd_after_dx", {15'b0, osdStb}, 16'd0);
        @(negedge clock);
        checkOutput("t2_osd_stb", {15'b0, osdStb}, 16'd1);
        checkOutput("t2_osd_code", {8'b0, osdCode}, 16'h0081);
        @(negedge clock);
        checkOutput("t2_osd_one_cycle", {15'b0, osdStb}, 16'd0);
        checkOutput("t2_osd_code_held", {8'b0, osdCode}, 16'h0081);

        // Saturation at both ends of the signed range.
        pulseMouseRd();
        checkOutput("t3_dx_cleared", {8'b0, mouseDx}, 16'd0);
        for (int i = 0; i < 20; i++) applyStimulus(KMS_MOUSE_X, 8'h7F, 1'b1);
        waitCycles(3);
        checkOutput("t3_dx_sat_pos", {8'b0, mouseDx}, 16'h007F);
        checkOutput("t3_level_drained", {12'b0, fifoLevel}, 16'd0);
        for (int i = 0; i < 20; i++) applyStimulus(KMS_MOUSE_X, 8'h80, 1'b1);
        waitCycles(3);
        checkOutput("t3_dx_sat_neg", {8'b0, mouseDx}, 16'h0080);
        checkOutput("t3_dy_untouched", {8'b0, mouseDy}, 16'd0);

        // mouse_rd coinciding with a Y pop: old value read, new delta kept.
        pulseMouseRd();
        checkOutput("t4_dx_cleared", {8'b0, mouseDx}, 16'd0);
        applyStimulus(KMS_MOUSE_Y, 8'd10, 1'b1);
        waitCycles(3);
        checkOutput("t4_dy_ten", {8'b0, mouseDy}, 16'h000A);
        applyStimulus(KMS_MOUSE_Y, 8'hFD, 1'b1);
        @(negedge clock);
        mouseRd = 1'b1;
        checkOutput("t4_dy_sampled", {8'b0, mouseDy}, 16'h000A);
        @(negedge clock);
        mouseRd = 1'b0;
        checkOutput("t4_dy_after_rd", {8'b0, mouseDy}, 16'h00FD);

        // FIFO full: ninth keycode dropped, then a push with a pop is accepted.
        base = kbdSeen;
        applyStimulus(KMS_KEY, 8'hA0, 1'b1);
        waitCycles(3);
        checkOutput("t5_req_pending", {15'b0, bus.kbd_req}, 16'd1);
        for (int i = 0; i < 9; i++) applyStimulus(KMS_KEY, 8'hB0 + 8'(i), i < 8);
        @(negedge clock);
        checkOutput("t5_level_full", {12'b0, fifoLevel}, 16'd8);
        checkOutput("t5_overflow", {15'b0, overflow}, 16'd1);
        bus.kbd_ack = 1'b1;
        applyStimulus(KMS_KEY, 8'hD0, 1'b1);
        bus.kbd_ack = 1'b0;
        @(negedge clock);
        checkOutput("t5_push_with_pop", {12'b0, fifoLevel}, 16'd8);
        for (int i = 0; i < 9; i++) begin
            waitReq(10);
            pulseAck();
        end
        waitCycles(3);
        #1;
        checkOutput("t5_level_empty", {12'b0, fifoLevel}, 16'd0);
        checkOutput("t5_sb_drained", 16'(sbQ.size()), 16'd0);
        checkOutput("t5_dispatch_count", 16'(kbdSeen - base), 16'd10);
        checkOutput("t5_overflow_sticky", {15'b0, overflow}, 16'd1);

        // Asynchronous reset in the middle of a handshake.
        applyStimulus(KMS_KEY, 8'hC0, 1'b1);
        waitCycles(3);
        checkOutput("t6_req_pending", {15'b0, bus.kbd_req}, 16'd1);
        for (int i = 0; i < 3; i++) applyStimulus(KMS_KEY, 8'hC1 + 8'(i), 1'b0);
        @(negedge clock);
        checkOutput("t6_level_queued", {12'b0, fifoLevel}, 16'd3);
        #2;
        resetN        = 1'b0;
        bus.kms_level = 1'b0;
        #1;
        checkOutput("t6_req_async", {15'b0, bus.kbd_req}, 16'd0);
        checkOutput("t6_level_reset", {12'b0, fifoLevel}, 16'd0);
        checkOutput("t6_overflow_reset", {15'b0, overflow}, 16'd0);
        sbQ.delete();
        base = kbdSeen;
        @(negedge clock);
        resetN = 1'b1;
        waitCycles(10);
        #1;
        checkOutput("t6_no_dispatch", 16'(kbdSeen - base), 16'd0);
        checkOutput("t6_req_idle", {15'b0, bus.kbd_req}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
